// File: rtl/dcache_data_responder.sv
// Data-side request tracker: forwards pipeline loads/stores to the memory bus with byte strobes,
// tracks outstanding transactions in order and returns registered responses tagged with a cancel flag.
module dcache_data_responder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        data_cancel,
  output logic        protocol_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] cancel_flags;
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (count == FULL_COUNT);
  assign mem_req   = req & ~full & ~flush;
  assign addr_ok   = mem_req & mem_addr_ok;
  assign mem_wr    = wr;
  assign mem_size  = size;
  assign mem_addr  = addr;
  assign mem_wdata = wdata;

  assign push = addr_ok;
  assign pop  = mem_data_ok & (count != '0);

  always_comb begin
    mem_wstrb = 4'b0000;
    if (wr) begin
      case (size)
        2'd0:    mem_wstrb = 4'b0001 << addr[1:0];
        2'd1:    mem_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        default: mem_wstrb = 4'b1111;
      endcase
    end
  end

  // Flags of empty slots may also be set by a flush; harmless since a push always rewrites its slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cancel_flags <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PW'(i))) begin
          cancel_flags[i] <= 1'b0;
        end else if (flush) begin
          cancel_flags[i] <= 1'b1;
        end
      end
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok     <= 1'b0;
      rdata       <= '0;
      data_cancel <= 1'b0;
    end else begin
      data_ok <= pop;
      if (pop) begin
        rdata       <= mem_rdata;
        data_cancel <= cancel_flags[rd_ptr] | flush;
      end
    end
  end

  // A bus response with nothing outstanding means the bus and tracker are out of sync.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      protocol_err <= 1'b0;
    end else if (mem_data_ok && (count == '0)) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_data_responder.sv
// Scoreboard bench for dcache_data_responder: expected responses are queued at issue time
// and compared when the DUT pulses data_ok.
module tb_dcache_data_responder;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] data;
    logic        cancel;
    int          due;
  } entry_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        data_cancel;
  logic        protocol_err;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  entry_t      pending[$];
  entry_t      resp[$];
  logic        exp_perr = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_cancel = 1'b0;

  dcache_data_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .data_cancel(data_cancel), .protocol_err(protocol_err), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [3:0] expStrobe(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (!w) return 4'b0000;
    if (sz == 2'd0) begin
      case (a[1:0])
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (sz == 2'd1) return (a[1] == 1'b0) ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  // One clock cycle of stimulus; the model decides acceptance and response bookkeeping.
  task automatic applyStimulus(input logic f, input logic r, input logic w, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd, input logic maok,
                               input logic mdok, input logic [31:0] new_data, output logic accepted);
    logic   exp_mreq;
    logic   exp_aok;
    entry_t e;
    @(posedge clk);
    #1;
    checkOutput("protocol_err", {31'd0, protocol_err}, {31'd0, exp_perr});
    flush       = f;
    req         = r;
    wr          = w;
    size        = sz;
    addr        = a;
    wdata       = wd;
    mem_addr_ok = maok;
    mem_data_ok = mdok;
    mem_rdata   = (pending.size() != 0) ? pending[0].data : $urandom();
    #1;
    exp_mreq = r & (pending.size() != DEPTH) & ~f;
    exp_aok  = exp_mreq & maok;
    checkOutput("mem_req", {31'd0, mem_req}, {31'd0, exp_mreq});
    checkOutput("addr_ok", {31'd0, addr_ok}, {31'd0, exp_aok});
    checkOutput("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, expStrobe(w, sz, a)});
    checkOutput("mem_addr", mem_addr, a);
    checkOutput("mem_wdata", mem_wdata, wd);
    checkOutput("mem_wr_size", {29'd0, mem_wr, mem_size}, {29'd0, w, sz});
    if (f) begin
      foreach (pending[i]) pending[i].cancel = 1'b1;
    end
    if (mdok) begin
      if (pending.size() != 0) begin
        e = pending.pop_front();
        e.due = cyc + 1;
        resp.push_back(e);
      end else begin
        exp_perr = 1'b1;
      end
    end
    if (exp_aok) begin
      e.data   = new_data;
      e.cancel = 1'b0;
      e.due    = 0;
      pending.push_back(e);
    end
    accepted = exp_aok;
  endtask

  task automatic idleCycles(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0, acc);
  endtask

  task automatic issueLoad(input logic [31:0] a, input logic [31:0] d);
    logic acc;
    applyStimulus(0, 1, 0, 2'd2, a, 32'h0, 1, 0, d, acc);
  endtask

  task automatic respond(input logic f);
    logic acc;
    applyStimulus(f, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0, acc);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    resetn      = 1'b0;
    flush       = 1'b0;
    req         = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    #1;
    checkOutput("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
    checkOutput("rst_data_ok", {31'd0, data_ok}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_data_cancel", {31'd0, data_cancel}, 32'd0);
    pending.delete();
    resp.delete();
    exp_perr    = 1'b0;
    last_rdata  = '0;
    last_cancel = 1'b0;
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  // Response monitor: data_ok must appear exactly one cycle after the bus response, in order.
  always @(negedge clk) begin
    entry_t e;
    if (resetn) begin
      checkOutput("data_ok", {31'd0, data_ok},
                  {31'd0, (resp.size() != 0) && (resp[0].due == cyc)});
      if (data_ok && resp.size() != 0) begin
        e = resp.pop_front();
        checkOutput("rdata", rdata, e.data);
        checkOutput("data_cancel", {31'd0, data_cancel}, {31'd0, e.cancel});
        last_rdata  = e.data;
        last_cancel = e.cancel;
      end else if (!data_ok) begin
        checkOutput("rdata_hold", rdata, last_rdata);
        checkOutput("cancel_hold", {31'd0, data_cancel}, {31'd0, last_cancel});
      end
    end
  end

  initial begin
    logic        acc;
    logic [31:0] next_data;
    int          budget;

    doReset();

    // Single load, response three cycles after acceptance
    issueLoad(32'h0000_1000, 32'hDEAD_BEEF);
    idleCycles(2);
    respond(0);
    idleCycles(2);

    // Store strobes, including an accepted store that gets a bus response
    applyStimulus(0, 1, 1, 2'd0, 32'h0000_2003, 32'hAA00_0000, 0, 0, 32'h0, acc);
    applyStimulus(0, 1, 1, 2'd1, 32'h0000_2002, 32'hBBBB_0000, 0, 0, 32'h0, acc);
    applyStimulus(0, 1, 1, 2'd2, 32'h0000_2000, 32'h1234_5678, 1, 0, 32'h0000_5555, acc);
    respond(0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(),
                    $urandom(), 0, 0, 32'h0, acc);
    end
    idleCycles(2);

    // Fill to DEPTH, third request must be refused, then interleave pushes and pops
    issueLoad(32'h0000_3000, 32'hA0);
    issueLoad(32'h0000_3004, 32'hA1);
    issueLoad(32'h0000_3008, 32'hFF);
    next_data = 32'hA2;
    budget = 0;
    while ((next_data <= 32'hA4 || pending.size() != 0) && budget < 20) begin
      applyStimulus(0, next_data <= 32'hA4, 0, 2'd2, 32'h0000_3000 + next_data, 32'h0, 1,
                    pending.size() != 0, next_data, acc);
      if (acc) next_data++;
      budget++;
    end
    checkOutput("wrap_budget", {31'd0, budget < 20}, 32'd1);
    idleCycles(2);

    // Flush with two loads outstanding; a request during flush is refused
    issueLoad(32'h0000_4000, 32'hB0);
    issueLoad(32'h0000_4004, 32'hB1);
    idleCycles(1);
    applyStimulus(1, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0, acc);
    respond(0);
    respond(0);
    applyStimulus(1, 1, 0, 2'd2, 32'h0000_4008, 32'h0, 1, 0, 32'hBF, acc);
    issueLoad(32'h0000_400C, 32'hB2);
    respond(0);
    idleCycles(2);

    // Flush coincident with a bus response, then a flush while data_ok is high
    issueLoad(32'h0000_5000, 32'hC0);
    issueLoad(32'h0000_5004, 32'hC1);
    respond(1);
    respond(0);
    issueLoad(32'h0000_5008, 32'hD0);
    respond(0);
    applyStimulus(1, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0, acc);
    idleCycles(2);
    checkOutput("drain_pending", pending.size(), 32'd0);
    checkOutput("drain_resp", resp.size(), 32'd0);

    // Spurious bus response after reset: sticky error, cleared by reset
    doReset();
    respond(0);
    idleCycles(3);
    doReset();
    idleCycles(2);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
